// File: rtl/voice_phrase_seq.sv
// voice_phrase_seq: phrase sequencer for the SP0256 speech path.
//
// Queues phrase numbers in a 4-entry FIFO, walks each phrase's allophone list in an
// external synchronous ROM (one slot of 2**SLOT_BITS bytes per phrase), and hands the
// allophones to the speech core over the address / ALD / LDQ handshake, one at a time.
//
// Ports (clk2m5 domain):
//   clk2m5_i       system clock
//   reset_i        asynchronous active-high reset
//   req_valid_i    phrase request valid
//   req_phrase_i   phrase number
//   req_ready_o    FIFO not full (registered)
//   rom_addr_o     allophone ROM address
//   rom_data_i     ROM byte: [7] end-of-phrase, [5:0] allophone, 1-cycle read latency
//   voice_addr_o   allophone code to the speech core
//   voice_ald_n_o  address-load strobe, active low
//   voice_ldq_i    core ready for next allophone (asynchronous, synchronised here)
//   busy_o         sequencer active or FIFO non-empty
//   timeout_err_o  sticky: a phrase was aborted waiting for LDQ
//
// Build option: define VOICE_SEQ_PAUSE_EN to append a PA1 pause (allophone 0x00) to every
// phrase that ends normally.
module voice_phrase_seq #(
  parameter int unsigned PW        = 4,
  parameter int unsigned SLOT_BITS = 4,
  parameter int unsigned ALD_CYC   = 3,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                    clk2m5_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  input  logic [PW-1:0]           req_phrase_i,
  output logic                    req_ready_o,
  output logic [PW+SLOT_BITS-1:0] rom_addr_o,
  input  logic [7:0]              rom_data_i,
  output logic [5:0]              voice_addr_o,
  output logic                    voice_ald_n_o,
  input  logic                    voice_ldq_i,
  output logic                    busy_o,
  output logic                    timeout_err_o
);

  localparam int unsigned AW = PW + SLOT_BITS;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = (ALD_CYC > 1) ? $clog2(ALD_CYC) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] StbInit = SW'(ALD_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRomWait,
    StWaitLdq,
    StStrobe,
    StNext,
    StDrain
`ifdef VOICE_SEQ_PAUSE_EN
    , StPause
`endif
  } state_e;

  // LDQ synchroniser
  logic ldq_meta_q, ldq_s_q;

  always_ff @(posedge clk2m5_i or posedge reset_i) begin
    if (reset_i) begin
      ldq_meta_q <= 1'b0;
      ldq_s_q    <= 1'b0;
    end else begin
      ldq_meta_q <= voice_ldq_i;
      ldq_s_q    <= ldq_meta_q;
    end
  end

  // Request FIFO
  logic [PW-1:0] fifo_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          req_ready_q;
  logic          push, pop;
  logic [PW-1:0] pop_phrase;
  state_e        state_q;

  assign push       = req_valid_i && req_ready_q;
  assign pop        = (state_q == StIdle) && (count_q != 3'd0);
  assign count_d    = count_q + 3'(push) - 3'(pop);
  assign pop_phrase = fifo_q[rd_ptr_q];

  always_ff @(posedge clk2m5_i) begin
    if (push) fifo_q[wr_ptr_q] <= req_phrase_i;
  end

  always_ff @(posedge clk2m5_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      req_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q     <= count_d;
      req_ready_q <= (count_d != 3'd4);
    end
  end

  // Sequencer
  logic [AW-1:0] ptr_q, rom_addr_q;
  logic          cur_end_q;
  logic [5:0]    cur_allo_q, voice_addr_q;
  logic          ald_n_q, timeout_err_q;
  logic [SW-1:0] stb_q;
  logic [TW-1:0] tmo_q;
  logic          last_in_slot, phrase_end;
  logic          unused_rom_bit;
`ifdef VOICE_SEQ_PAUSE_EN
  logic          pause_q;
`endif

  assign last_in_slot   = &ptr_q[SLOT_BITS-1:0];
  assign phrase_end     = cur_end_q || last_in_slot;
  assign unused_rom_bit = rom_data_i[6];

  // rom_addr also follows ptr whenever ptr moves, so the ROM has already registered the
  // byte at ptr by the end of FETCH and ROMWAIT sees valid data despite the read latency.
  always_ff @(posedge clk2m5_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      rom_addr_q    <= '0;
      cur_end_q     <= 1'b0;
      cur_allo_q    <= 6'd0;
      voice_addr_q  <= 6'd0;
      ald_n_q       <= 1'b1;
      stb_q         <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
`ifdef VOICE_SEQ_PAUSE_EN
      pause_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            ptr_q      <= {pop_phrase, {SLOT_BITS{1'b0}}};
            rom_addr_q <= {pop_phrase, {SLOT_BITS{1'b0}}};
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          rom_addr_q <= ptr_q;
          state_q    <= StRomWait;
        end
        StRomWait: begin
          cur_end_q  <= rom_data_i[7];
          cur_allo_q <= rom_data_i[5:0];
          tmo_q      <= '0;
          state_q    <= StWaitLdq;
        end
        StWaitLdq: begin
          if (ldq_s_q) begin
            voice_addr_q <= cur_allo_q;
            ald_n_q      <= 1'b0;
            stb_q        <= StbInit;
            state_q      <= StStrobe;
          end else if (tmo_q == TmoLast) begin
            // Abort the phrase; queued requests stay in the FIFO.
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
`ifdef VOICE_SEQ_PAUSE_EN
            pause_q       <= 1'b0;
`endif
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StStrobe: begin
          if (stb_q == '0) begin
            ald_n_q <= 1'b1;
            state_q <= StNext;
          end else begin
            stb_q <= stb_q - SW'(1);
          end
        end
        StNext: begin
`ifdef VOICE_SEQ_PAUSE_EN
          if (pause_q) begin
            state_q <= StDrain;
          end else if (phrase_end) begin
            state_q <= StPause;
          end else begin
`else
          if (phrase_end) begin
            state_q <= StIdle;
          end else begin
`endif
            ptr_q      <= ptr_q + AW'(1);
            rom_addr_q <= ptr_q + AW'(1);
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          if (!ldq_s_q) begin
`ifdef VOICE_SEQ_PAUSE_EN
            if (pause_q) begin
              pause_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q <= StFetch;
            end
`else
            state_q <= StFetch;
`endif
          end
        end
`ifdef VOICE_SEQ_PAUSE_EN
        StPause: begin
          // PA1 pause comes from here, not from the ROM.
          cur_end_q  <= 1'b0;
          cur_allo_q <= 6'd0;
          tmo_q      <= '0;
          pause_q    <= 1'b1;
          state_q    <= StWaitLdq;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rom_addr_o    = rom_addr_q;
  assign voice_addr_o  = voice_addr_q;
  assign voice_ald_n_o = ald_n_q;
  assign timeout_err_o = timeout_err_q;
  assign busy_o        = (state_q != StIdle) || (count_q != 3'd0);

endmodule

// File: tb/tb_voice_phrase_seq.sv
// Self-checking bench for voice_phrase_seq: ROM and LDQ models, scoreboard of expected
// allophones filled at request time and drained by the strobe monitor.
module tb_voice_phrase_seq;

  localparam int ALD = 3;

  logic       clk, rst;
  logic       req_valid, req_ready;
  logic [3:0] req_phrase;
  logic [7:0] rom_addr, rom_data;
  logic [5:0] voice_addr;
  logic       voice_ald_n, voice_ldq, busy, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom_mem [256];
  logic [5:0] exp_q [$];

  voice_phrase_seq #(
    .PW(4), .SLOT_BITS(4), .ALD_CYC(ALD), .TIMEOUT(100)
  ) dut (
    .clk2m5_i      (clk),
    .reset_i       (rst),
    .req_valid_i   (req_valid),
    .req_phrase_i  (req_phrase),
    .req_ready_o   (req_ready),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .voice_addr_o  (voice_addr),
    .voice_ald_n_o (voice_ald_n),
    .voice_ldq_i   (voice_ldq),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Speech core: LDQ drops on ALD, rises 10 cycles after ALD release.
  bit ldq_force_low = 1'b0;
  int rel_cnt = 0;
  initial voice_ldq = 1'b1;
  always @(posedge clk) begin
    if (ldq_force_low || !voice_ald_n) begin
      voice_ldq <= 1'b0;
      rel_cnt   <= 0;
    end else if (!voice_ldq) begin
      if (rel_cnt == 9) voice_ldq <= 1'b1;
      else rel_cnt <= rel_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops one expected allophone per ALD, checks ALD width.
  int strobes = 0;
  int low_len = 0;
  bit in_strobe = 1'b0;
  bit seen50 = 1'b0;
  always @(negedge clk) begin
    if (rom_addr == 8'h50) seen50 = 1'b1;
    if (rst) begin
      in_strobe = 1'b0;
    end else if (!voice_ald_n) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        low_len   = 1;
        strobes++;
        check("strobe_queued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("voice_addr", 32'(voice_addr), 32'(exp_q.pop_front()));
      end else begin
        low_len++;
      end
    end else if (in_strobe) begin
      in_strobe = 1'b0;
      check("ald_low_cycles", 32'(low_len), 32'(ALD));
    end
  end

  task automatic add_expected(input logic [3:0] p);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = rom_mem[{p, 4'(i)}];
      exp_q.push_back(b[5:0]);
      if (b[7]) break;
    end
`ifdef VOICE_SEQ_PAUSE_EN
    exp_q.push_back(6'h00);
`endif
  endtask

  int last_wait = 0;
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [3:0] p, input bit speaks);
    int n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("push_ready_wait", 32'(req_ready), 32'd1);
    last_wait  = n;
    req_valid  = 1'b1;
    req_phrase = p;
    if (speaks) add_expected(p);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_all_spoken"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, n, extra;
    extra = 0;
`ifdef VOICE_SEQ_PAUSE_EN
    extra = 1;
`endif
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 16; i++) rom_mem[p * 16 + i] = 8'h3F;
      rom_mem[p * 16]     = 8'(p + 8'h10);
      rom_mem[p * 16 + 1] = 8'h80 | 8'(p + 8'h20);
    end
    rom_mem[8'h20] = 8'h15;
    rom_mem[8'h21] = 8'h2A;
    rom_mem[8'h22] = 8'h83;
    for (int i = 0; i < 16; i++) rom_mem[8'h40 + i] = 8'(i + 1);

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_phrase = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ald_n", 32'(voice_ald_n), 32'd1);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_voice_addr", 32'(voice_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Phrase 2: 0x15, 0x2A, 0x03
    s0 = strobes;
    push(4'd2, 1'b1);
    wait_idle(500, "ph2");
    check("ph2_strobes", 32'(strobes - s0), 32'(3 + extra));
    check("ph2_addr_hold", 32'(voice_addr), extra ? 32'h00 : 32'h03);

    // Burst of five back-to-back requests, then one more that must wait
    repeat (5) @(negedge clk);
    push(4'd1, 1'b1);
    push(4'd3, 1'b1);
    push(4'd5, 1'b1);
    push(4'd7, 1'b1);
    push(4'd9, 1'b1);
    check("burst_full", 32'(req_ready), 32'd0);
    check("burst_busy", 32'(busy), 32'd1);
    push(4'd11, 1'b1);
    check("burst_waited_for_ready", 32'(last_wait > 0), 32'd1);
    wait_idle(3000, "burst");

    // Phrase 4: full slot without end bit
    repeat (5) @(negedge clk);
    seen50 = 1'b0;
    s0 = strobes;
    push(4'd4, 1'b1);
    wait_idle(2000, "ph4");
    check("ph4_strobes", 32'(strobes - s0), 32'(16 + extra));
    check("ph4_ptr_stop", 32'(rom_addr), 32'h4F);
    check("ph4_no_wrap", 32'(seen50), 32'd0);

    // Timeout on phrase 6, phrase 8 follows
    repeat (5) @(negedge clk);
    ldq_force_low = 1'b1;
    repeat (5) @(negedge clk);
    push(4'd6, 1'b0);
    push(4'd8, 1'b1);
    n = 0;
    while (rom_addr != 8'h60 && n < 20) begin @(negedge clk); n++; end
    check("tmo_fetch6", 32'(rom_addr), 32'h60);
    n = 0;
    while (!timeout_err && n < 300) begin @(negedge clk); n++; end
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    check("tmo_cycles", 32'(n), 32'd102);
    n = 0;
    while (rom_addr != 8'h80 && n < 5) begin @(negedge clk); n++; end
    check("tmo_next_fetch", 32'(rom_addr), 32'h80);
    ldq_force_low = 1'b0;
    wait_idle(1000, "ph8");
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during a strobe of phrase 2
    repeat (5) @(negedge clk);
    push(4'd2, 1'b1);
    n = 0;
    while (voice_ald_n && n < 300) begin @(negedge clk); n++; end
    check("rst_strobe_seen", 32'(voice_ald_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_ald_n", 32'(voice_ald_n), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_err_clr", 32'(timeout_err), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = strobes;
    repeat (60) @(negedge clk);
    check("post_rst_no_strobe", 32'(strobes - s0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    push(4'd3, 1'b1);
    wait_idle(500, "post_rst");
    check("post_rst_strobes", 32'(strobes - s0), 32'(2 + extra));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
